// File: rtl/spi_frame_buffer_if.sv
// spi_frame_buffer_if: groups the SPI pins, the reply-word handshake and the captured-frame outputs.
// Latency: none; this is wiring only.
// Backpressure: none; slave = frame buffer side, master = pin driver / command decoder side.
interface spi_frame_buffer_if #(
   parameter int WORD_WIDTH = 8,
   parameter int DEPTH      = 4,
   parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) ();
   logic                          spi_sclk;
   logic                          spi_cs_n;
   logic                          spi_mosi;
   logic                          spi_miso;
   logic [WORD_WIDTH-1:0]         tx_word;
   logic                          tx_load;
   logic [DEPTH*WORD_WIDTH-1:0]   rx_flat;
   logic [CNT_WIDTH-1:0]          rx_count;
   logic                          word_valid;
   logic                          frame_active;
   logic                          frame_done;
   logic                          overflow;

   modport slave (
      input  spi_sclk, spi_cs_n, spi_mosi, tx_word,
      output spi_miso, tx_load, rx_flat, rx_count, word_valid,
             frame_active, frame_done, overflow
   );

   modport master (
      output spi_sclk, spi_cs_n, spi_mosi, tx_word,
      input  spi_miso, tx_load, rx_flat, rx_count, word_valid,
             frame_active, frame_done, overflow
   );
endinterface

// File: rtl/spi_frame_buffer.sv
// spi_frame_buffer: SPI mode-0 slave capturing one chip-select frame of words into a register array.
// Latency: 3 sys_clk cycles from an SPI pin change to its effect; MISO reply word loaded on tx_load.
// Backpressure: none; tx_word must be valid whenever tx_load pulses. SPI_FRAME_BUFFER_ECHO_EN echoes MOSI.
module spi_frame_buffer #(
   parameter int WORD_WIDTH = 8,
   parameter int DEPTH      = 4,
   parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
   input logic               sys_clk,
   input logic               reset,
   spi_frame_buffer_if.slave bus
);
   localparam int                    BIT_WIDTH = $clog2(WORD_WIDTH);
   localparam logic [BIT_WIDTH-1:0]  LAST_BIT  = BIT_WIDTH'(WORD_WIDTH - 1);
   localparam logic [CNT_WIDTH-1:0]  FULL      = CNT_WIDTH'(DEPTH);

   typedef enum logic [1:0] {
      WAIT_IDLE = 2'd0,
      IDLE      = 2'd1,
      ACTIVE    = 2'd2
   } state_t;

   state_t state, next_state;

   // Bit 1 is the synchronised value, bit 2 its delayed copy for edge detection.
   logic [2:0] sclk_sync;
   logic [2:0] cs_sync;
   logic [1:0] mosi_sync;
   // Counts edges since reset so the synchronisers hold real pin samples, not reset values.
   logic [1:0] sync_warm;
   logic       sync_ready;

   logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_bit;

   logic start_frame, bit_in, bit_out, end_frame;

   logic [BIT_WIDTH-1:0]          bit_cnt;
   logic [WORD_WIDTH-2:0]         rx_shift;
   logic [WORD_WIDTH-1:0]         new_word;
   logic [WORD_WIDTH-1:0]         tx_shift;
   logic [WORD_WIDTH-1:0]         rx_mem [DEPTH];
   logic [CNT_WIDTH-1:0]          rx_count_q;
   logic                          word_valid_q;
   logic                          frame_done_q;
   logic                          overflow_q;
   logic                          tx_load_q;
   logic [DEPTH*WORD_WIDTH-1:0]   rx_flat_w;
   logic [WORD_WIDTH-1:0]         tx_first;
   logic [WORD_WIDTH-1:0]         tx_reload;

`ifdef SPI_FRAME_BUFFER_ECHO_EN
   // Loopback: reply with the word received just before, zero for the first word.
   localparam logic LOAD_PULSE = 1'b0;
   assign tx_first  = '0;
   assign tx_reload = new_word;
`else
   localparam logic LOAD_PULSE = 1'b1;
   assign tx_first  = bus.tx_word;
   assign tx_reload = bus.tx_word;
`endif

   assign sync_ready = (sync_warm == 2'd3);
   assign sclk_rise  = sclk_sync[1] & ~sclk_sync[2];
   assign sclk_fall  = ~sclk_sync[1] & sclk_sync[2];
   assign cs_rise    = cs_sync[1] & ~cs_sync[2];
   assign cs_fall    = ~cs_sync[1] & cs_sync[2];
   assign mosi_bit   = mosi_sync[1];
   assign new_word   = {rx_shift, mosi_bit};

   // Bring the asynchronous SPI pins into the sys_clk domain.
   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         sclk_sync <= 3'b000;
         cs_sync   <= 3'b111;
         mosi_sync <= 2'b00;
         sync_warm <= 2'd0;
      end else begin
         sclk_sync <= {sclk_sync[1:0], bus.spi_sclk};
         cs_sync   <= {cs_sync[1:0], bus.spi_cs_n};
         mosi_sync <= {mosi_sync[0], bus.spi_mosi};
         if (!sync_ready) begin
            sync_warm <= sync_warm + 2'd1;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         state <= WAIT_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state and per-cycle datapath commands.
   always_comb begin
      next_state  = state;
      start_frame = 1'b0;
      bit_in      = 1'b0;
      bit_out     = 1'b0;
      end_frame   = 1'b0;
      case (state)
         WAIT_IDLE: begin
            // Leave only once a genuine deselected level has been observed.
            if (sync_ready && cs_sync[1]) begin
               next_state = IDLE;
            end
         end
         IDLE: begin
            if (cs_fall) begin
               next_state  = ACTIVE;
               start_frame = 1'b1;
            end
         end
         ACTIVE: begin
            bit_in  = sclk_rise;
            bit_out = sclk_fall;
            if (cs_rise) begin
               next_state = IDLE;
               end_frame  = 1'b1;
            end
         end
         default: next_state = WAIT_IDLE;
      endcase
   end

   // Shift registers, word storage, counters and status strobes.
   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         bit_cnt      <= '0;
         rx_shift     <= '0;
         tx_shift     <= '0;
         rx_count_q   <= '0;
         word_valid_q <= 1'b0;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
         tx_load_q    <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            rx_mem[i] <= '0;
         end
      end else begin
         word_valid_q <= 1'b0;
         frame_done_q <= 1'b0;
         tx_load_q    <= 1'b0;

         if (start_frame) begin
            rx_count_q <= '0;
            overflow_q <= 1'b0;
            bit_cnt    <= '0;
            tx_shift   <= tx_first;
            tx_load_q  <= LOAD_PULSE;
         end

         if (bit_in) begin
            rx_shift <= new_word[WORD_WIDTH-2:0];
            if (bit_cnt == LAST_BIT) begin
               bit_cnt      <= '0;
               word_valid_q <= 1'b1;
               tx_shift     <= tx_reload;
               tx_load_q    <= LOAD_PULSE;
               if (rx_count_q != FULL) begin
                  for (int i = 0; i < DEPTH; i++) begin
                     if (rx_count_q == CNT_WIDTH'(i)) begin
                        rx_mem[i] <= new_word;
                     end
                  end
                  rx_count_q <= rx_count_q + CNT_WIDTH'(1);
               end else begin
                  overflow_q <= 1'b1;
               end
            end else begin
               bit_cnt <= bit_cnt + BIT_WIDTH'(1);
            end
         end

         // Hold a freshly loaded MSB through the first rising edge of a word.
         if (bit_out && (bit_cnt != '0)) begin
            tx_shift <= {tx_shift[WORD_WIDTH-2:0], 1'b0};
         end

         // Frame end drops any partial word; a word completing this cycle is already stored.
         if (end_frame) begin
            frame_done_q <= 1'b1;
            bit_cnt      <= '0;
         end
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_flat
      assign rx_flat_w[g*WORD_WIDTH +: WORD_WIDTH] = rx_mem[g];
   end

   assign bus.rx_flat      = rx_flat_w;
   assign bus.rx_count     = rx_count_q;
   assign bus.word_valid   = word_valid_q;
   assign bus.frame_done   = frame_done_q;
   assign bus.overflow     = overflow_q;
   assign bus.tx_load      = tx_load_q;
   assign bus.frame_active = (state == ACTIVE);
   assign bus.spi_miso     = (state == ACTIVE) & tx_shift[WORD_WIDTH-1];

endmodule

// File: tb/tb_spi_frame_buffer.sv
// tb_spi_frame_buffer: drives randomized SPI frames and compares against a word-level frame model.
// Latency: SCLK half period is 8 sys_clk cycles, well inside the synchroniser budget.
// Backpressure: none; tx_word is refreshed after each tx_load pulse and the consumed values are logged.
module tb_spi_frame_buffer;
   localparam int W    = 8;
   localparam int D    = 4;
   localparam int CW   = $clog2(D + 1);
   localparam int HALF = 80;

   logic sys_clk = 1'b0;
   logic reset   = 1'b1;
   always #5 sys_clk = ~sys_clk;

   spi_frame_buffer_if #(.WORD_WIDTH(W), .DEPTH(D), .CNT_WIDTH(CW)) bus ();

   spi_frame_buffer #(.WORD_WIDTH(W), .DEPTH(D), .CNT_WIDTH(CW)) dut (
      .sys_clk (sys_clk),
      .reset   (reset),
      .bus     (bus)
   );

   int chk_cnt  = 0;
   int pass_cnt = 0;

   // Reply-word source and event counters, sampled away from the active edge.
   logic [W-1:0] tx_val = 8'h80;
   logic [W-1:0] tx_log [512];
   int           tx_wr  = 0;
   int           wv_cnt = 0;
   int           fd_cnt = 0;
   assign bus.tx_word = tx_val;

   always @(negedge sys_clk) begin
      if (bus.word_valid) wv_cnt++;
      if (bus.frame_done) fd_cnt++;
      if (bus.tx_load) begin
         tx_log[tx_wr % 512] = tx_val;
         tx_wr++;
         tx_val = (tx_wr < 3) ? tx_val + 8'd1 : W'($urandom);
      end
   end

   // Frame model: words land in order until the array is full; the rest set overflow.
   logic [W-1:0] exp_mem [D];
   int           exp_cnt;
   bit           exp_ovf;
   logic [W-1:0] frame_dat [8];

   function automatic logic [D*W-1:0] model_flat();
      logic [D*W-1:0] v;
      v = '0;
      for (int i = 0; i < D; i++) v[i*W +: W] = exp_mem[i];
      return v;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < D; i++) exp_mem[i] = '0;
      exp_cnt = 0;
      exp_ovf = 0;
   endtask

   task automatic model_word(input logic [W-1:0] w);
      if (exp_cnt < D) begin
         exp_mem[exp_cnt] = w;
         exp_cnt++;
      end else begin
         exp_ovf = 1;
      end
   endtask

   task automatic spi_bit(input logic b, input bit cs_up, output logic m);
      bus.spi_mosi = b;
      #HALF;
      m = bus.spi_miso;
      bus.spi_sclk = 1'b1;
      if (cs_up) bus.spi_cs_n = 1'b1;
      #HALF;
      bus.spi_sclk = 1'b0;
   endtask

   task automatic spi_word(input logic [W-1:0] w, input bit cs_up, output logic [W-1:0] got);
      logic m;
      for (int i = W - 1; i >= 0; i--) begin
         spi_bit(w[i], cs_up && (i == 0), m);
         got[i] = m;
      end
   endtask

   // One frame of n words, optional trailing partial bits, optional cs rise on the last edge.
   task automatic do_frame(input int n, input int extra, input bit cs_with_last);
      int           wv0, fd0, tx0, exp_tx;
      logic [W-1:0] got, expm, prev;
      logic         m;
      wv0 = wv_cnt; fd0 = fd_cnt; tx0 = tx_wr; prev = '0;
      exp_cnt = 0; exp_ovf = 0;
      bus.spi_cs_n = 1'b0;
      repeat (6) @(negedge sys_clk);
      chk_cnt++;
      if (bus.rx_count !== CW'(0) || bus.overflow !== 1'b0 || bus.frame_active !== 1'b1)
         $display("FAIL frame_start: cnt=%0d ovf=%b act=%b, want 0 0 1", bus.rx_count, bus.overflow, bus.frame_active);
      else pass_cnt++;
      for (int k = 0; k < n; k++) begin
`ifdef SPI_FRAME_BUFFER_ECHO_EN
         expm = prev;
`else
         expm = tx_log[(tx0 + k) % 512];
`endif
         spi_word(frame_dat[k], cs_with_last && (k == n - 1) && (extra == 0), got);
         model_word(frame_dat[k]);
         prev = frame_dat[k];
         repeat (4) @(negedge sys_clk);
         chk_cnt++;
         if (got !== expm) $display("FAIL miso_word%0d: got %h want %h", k, got, expm);
         else pass_cnt++;
         chk_cnt++;
         if (bus.rx_count !== CW'(exp_cnt) || bus.overflow !== exp_ovf)
            $display("FAIL word%0d_status: cnt=%0d ovf=%b want %0d %b", k, bus.rx_count, bus.overflow, exp_cnt, exp_ovf);
         else pass_cnt++;
      end
      for (int b = 0; b < extra; b++) spi_bit(1'($urandom), 1'b0, m);
      if (!(cs_with_last && extra == 0)) begin
         #HALF;
         bus.spi_cs_n = 1'b1;
      end
      repeat (8) @(negedge sys_clk);
`ifdef SPI_FRAME_BUFFER_ECHO_EN
      exp_tx = 0;
`else
      exp_tx = n + 1;
`endif
      chk_cnt++;
      if (wv_cnt - wv0 !== n || fd_cnt - fd0 !== 1 || tx_wr - tx0 !== exp_tx)
         $display("FAIL frame_pulses: wv=%0d fd=%0d tx=%0d want %0d 1 %0d", wv_cnt - wv0, fd_cnt - fd0, tx_wr - tx0, n, exp_tx);
      else pass_cnt++;
      chk_cnt++;
      if (bus.rx_flat !== model_flat() || bus.rx_count !== CW'(exp_cnt) || bus.overflow !== exp_ovf)
         $display("FAIL frame_end: flat=%h cnt=%0d ovf=%b want %h %0d %b", bus.rx_flat, bus.rx_count, bus.overflow, model_flat(), exp_cnt, exp_ovf);
      else pass_cnt++;
      chk_cnt++;
      if (bus.frame_active !== 1'b0 || bus.spi_miso !== 1'b0)
         $display("FAIL frame_idle: act=%b miso=%b want 0 0", bus.frame_active, bus.spi_miso);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge sys_clk);
      chk_cnt++;
      if (bus.rx_flat !== '0 || bus.rx_count !== CW'(0) || bus.word_valid !== 1'b0 || bus.frame_active !== 1'b0 ||
          bus.frame_done !== 1'b0 || bus.overflow !== 1'b0 || bus.tx_load !== 1'b0 || bus.spi_miso !== 1'b0)
         $display("FAIL reset_values: flat=%h cnt=%0d wv=%b act=%b fd=%b ovf=%b tl=%b miso=%b want all 0",
                  bus.rx_flat, bus.rx_count, bus.word_valid, bus.frame_active, bus.frame_done, bus.overflow, bus.tx_load, bus.spi_miso);
      else pass_cnt++;
      reset = 1'b0;
      model_clear();
      repeat (8) @(negedge sys_clk);
      chk_cnt++;
      if (bus.frame_active !== 1'b0 || bus.rx_count !== CW'(0))
         $display("FAIL reset_release: act=%b cnt=%0d want 0 0", bus.frame_active, bus.rx_count);
      else pass_cnt++;
   endtask

   task automatic test_basic();
      frame_dat[0] = 8'hA5; frame_dat[1] = 8'h3C; frame_dat[2] = 8'hFF;
      do_frame(3, 0, 1'b0);
   endtask

   task automatic test_overflow();
      for (int k = 0; k < 6; k++) frame_dat[k] = W'(k + 1);
      do_frame(6, 0, 1'b0);
   endtask

   task automatic test_partial();
      frame_dat[0] = W'($urandom);
      do_frame(1, 5, 1'b0);
   endtask

   task automatic test_simultaneous();
      frame_dat[0] = W'($urandom); frame_dat[1] = W'($urandom);
      do_frame(2, 0, 1'b1);
   endtask

   task automatic test_random();
      for (int f = 0; f < 4; f++) begin
         int n;
         n = $urandom_range(6, 1);
         for (int k = 0; k < n; k++) frame_dat[k] = W'($urandom);
         do_frame(n, $urandom_range(W - 1, 0), 1'b0);
      end
   endtask

   task automatic test_idle_sclk();
      int   wv0;
      logic m;
      wv0 = wv_cnt;
      for (int b = 0; b < W; b++) spi_bit(1'($urandom), 1'b0, m);
      repeat (6) @(negedge sys_clk);
      chk_cnt++;
      if (wv_cnt - wv0 !== 0 || bus.rx_count !== CW'(exp_cnt) || bus.frame_active !== 1'b0)
         $display("FAIL idle_sclk: wv=%0d cnt=%0d act=%b want 0 %0d 0", wv_cnt - wv0, bus.rx_count, exp_cnt, bus.frame_active);
      else pass_cnt++;
   endtask

   task automatic test_reset_midframe();
      int           wv0, fd0;
      logic         m;
      logic [W-1:0] got;
      bus.spi_cs_n = 1'b0;
      repeat (6) @(negedge sys_clk);
      for (int b = 0; b < 4; b++) spi_bit(1'($urandom), 1'b0, m);
      reset = 1'b1;
      model_clear();
      repeat (3) @(negedge sys_clk);
      reset = 1'b0;
      wv0 = wv_cnt; fd0 = fd_cnt;
      for (int b = 0; b < 4; b++) spi_bit(1'($urandom), 1'b0, m);
      spi_word(W'($urandom), 1'b0, got);
      repeat (6) @(negedge sys_clk);
      chk_cnt++;
      if (wv_cnt - wv0 !== 0 || bus.rx_count !== CW'(0) || bus.frame_active !== 1'b0 || bus.rx_flat !== model_flat())
         $display("FAIL reset_midframe_capture: wv=%0d cnt=%0d act=%b flat=%h want 0 0 0 %h",
                  wv_cnt - wv0, bus.rx_count, bus.frame_active, bus.rx_flat, model_flat());
      else pass_cnt++;
      #HALF;
      bus.spi_cs_n = 1'b1;
      repeat (8) @(negedge sys_clk);
      chk_cnt++;
      if (fd_cnt - fd0 !== 0)
         $display("FAIL reset_midframe_done: fd=%0d want 0", fd_cnt - fd0);
      else pass_cnt++;
      frame_dat[0] = W'($urandom); frame_dat[1] = W'($urandom);
      do_frame(2, 0, 1'b0);
   endtask

   task automatic test_back_to_back();
      for (int f = 0; f < 2; f++) begin
         for (int k = 0; k < 3; k++) frame_dat[k] = W'($urandom);
         do_frame(3, 0, 1'b0);
      end
   endtask

   initial begin
      bus.spi_sclk = 1'b0;
      bus.spi_cs_n = 1'b1;
      bus.spi_mosi = 1'b0;
      model_clear();
      test_reset();
      test_basic();
      test_overflow();
      test_partial();
      test_simultaneous();
      test_idle_sclk();
      test_random();
      test_reset_midframe();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule

// File: doc/spi_frame_buffer.md
Name: spi_frame_buffer

Overview:
- Parametrised SPI slave (mode 0, MSB first) that captures a whole chip-select frame of WORD_WIDTH-bit words into a DEPTH-entry register array.
- Drives reply words on MISO and flags frame completion and overflow to sys_clk-domain command decoders.
- Successor to the fixed 4x8-bit command buffer: configurable width and depth, an explicit frame-done strobe, overflow detection, and a TX word request handshake.
- Sits between the MCU SPI pins and the bus-master command logic.

Parameters:
- WORD_WIDTH, 8, bits per SPI word (2..32).
- DEPTH, 4, number of stored words per frame (1..64).
- CNT_WIDTH, $clog2(DEPTH+1), width of rx_count.

Ports:
- reset  in  1  asynchronous, active-high reset.
- sys_clk  in  1  system clock; the block is fully synchronous to it. SCLK must be at most sys_clk/8.
- spi_sclk  in  1  SPI clock, asynchronous.
- spi_cs_n  in  1  chip select, active-low, asynchronous.
- spi_mosi  in  1  serial data in.
- spi_miso  out  1  serial data out; always driven, never tristated.
- tx_word  in  WORD_WIDTH  next reply word; sampled on the cycle tx_load=1.
- tx_load  out  1  one-cycle pulse: tx_word was consumed this cycle.
- rx_flat  out  DEPTH*WORD_WIDTH  stored words; word i occupies [i*WORD_WIDTH +: WORD_WIDTH].
- rx_count  out  CNT_WIDTH  words stored this frame; saturates at DEPTH.
- word_valid  out  1  one-cycle pulse when a complete word is received.
- frame_active  out  1  high while in ACTIVE.
- frame_done  out  1  one-cycle pulse on frame end.
- overflow  out  1  more than DEPTH words received this frame.

Behaviour:
- Reset is asynchronous and active-high; the clock is sys_clk.
- Reset values:
  - rx array all 0; rx_count, word_valid, frame_active, frame_done, overflow, tx_load, spi_miso all 0.
  - Synchronisers hold sclk=0, cs_n=1, mosi=0.
  - FSM state is WAIT_IDLE.
- Synchronisers:
  - spi_sclk, spi_cs_n and spi_mosi each pass through 2 flip-flops.
  - Edges are detected on the synchronised values using a third delayed copy.
  - Input-to-action latency is 3 sys_clk cycles.
- FSM states:
  - WAIT_IDLE: go to IDLE when synchronised cs_n=1. This prevents a frame that was in progress at reset release from being captured mid-word.
  - IDLE: on a cs_n falling edge, go to ACTIVE. In the same cycle:
    - clear rx_count, overflow and bit_cnt;
    - load tx_shift <= tx_word and pulse tx_load.
  - ACTIVE: handles rising and falling SCLK edges and the cs_n rising edge as described below.
- ACTIVE, SCLK rising edge:
  - Shift mosi into rx_shift LSB; bit_cnt++.
  - When bit_cnt reaches WORD_WIDTH-1 (word complete):
    - If rx_count<DEPTH: write rx[rx_count] <= completed word, rx_count++.
    - Else: discard the word, set overflow=1 (sticky until next frame), rx_count stays DEPTH.
    - In all cases: pulse word_valid, bit_cnt <= 0, tx_shift <= tx_word, pulse tx_load.
- ACTIVE, SCLK falling edge: shift tx_shift left by 1 only when bit_cnt != 0, so the freshly loaded MSB is held for the first rising edge.
- ACTIVE, cs_n rising edge:
  - Go to IDLE; pulse frame_done; frame_active <= 0.
  - Discard a partial word (bit_cnt!=0) without changing rx_count; reset bit_cnt.
- Simultaneous word completion and cs_n rise in the same cycle: process the word first (stored, word_valid=1), then frame_done=1 in that same cycle.
- spi_miso = tx_shift[WORD_WIDTH-1] while frame_active, else 0.
- rx array and rx_count are held after frame end until the next cs_n falling edge. Stale entries at or above rx_count are never cleared mid-operation.
- SCLK edges while in IDLE or WAIT_IDLE are ignored.
- Reset asserted mid-frame returns to WAIT_IDLE; captured data is lost.

Optional Feature:
- Macro: SPI_FRAME_BUFFER_ECHO_EN.
- When defined:
  - tx_word is ignored and tx_load is tied to 0.
  - tx_shift is loaded with the previous word received in this frame (0 for the first word), so MISO echoes MOSI delayed by one word.
  - Intended for link bring-up and loopback tests.
- When undefined: normal tx_word/tx_load behaviour as above.

Test Plan:
- WORD_WIDTH=8, DEPTH=4, frame of 3 words 0xA5,0x3C,0xFF → rx[0..2]=A5,3C,FF; rx_count=3; 3 word_valid pulses; one frame_done; overflow=0.
- DEPTH=4, frame of 6 words 0x01..0x06 → rx=01,02,03,04; rx_count=4; overflow=1 from the 5th word until the next cs_n fall.
- tx_word returns 0x80,0x81,0x82 on successive tx_load pulses; 3-word frame → MISO bytes 0x80,0x81,0x82; 4 tx_load pulses (one at frame start, one per completed word).
- WORD_WIDTH=12, frame with 1 full word 0xABC plus 5 extra bits, then cs_n rises → rx[0]=0xABC, rx_count=1, frame_done pulse, partial bits dropped.
- Assert reset during bit 4 of a word with cs_n low, release with cs_n still low → no capture until cs_n goes high and falls again; the next frame then captures normally.
- With SPI_FRAME_BUFFER_ECHO_EN defined, frame 0x11,0x22,0x33 → MISO 0x00,0x11,0x22.
